washer_plant_model: RTL and testbench

Synthesizable plant model of the washing machine appliance, for hardware-in-the-loop test of washing_machine_controller. It takes the controller's actuator commands and produces its sensor inputs: water level, temperature ADC, tachometer, vibration and door-lock feedback. The physics updates on a divided tick. Every output is registered.

---
 rtl/washer_plant_model.sv | 239 +++++++++++++++++++++++
 tb/tb_washer_plant_model.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/washer_plant_model.sv
// washer_plant_model: hardware-in-the-loop plant for the washing machine
// controller. Actuator commands in, simulated sensor readings out. The
// physics advances once per tick (every TICK_DIV clocks) using the commands
// present at that edge; every output comes straight from a flop.
//
// Optional build macro FAULT_INJECT_EN adds input fault_inject[1:0]:
//   bit0 forces vibration_sensor high at the next tick,
//   bit1 models a failed heater element (temperature only drifts to ambient).
//
// door state | meaning
// UNLOCKED   | door free, door_locked=0
// LOCKING    | lock in progress, door_locked=0, counts DOOR_DELAY ticks
// LOCKED     | door held, door_locked=1, unlock only when drum still and nearly empty
// UNLOCKING  | unlock in progress, door_locked=1, counts DOOR_DELAY ticks

module washer_plant_model #(
  parameter int TICK_DIV        = 16,
  parameter int FILL_RATE       = 8,
  parameter int DRAIN_RATE      = 16,
  parameter int HEAT_RATE       = 2,
  parameter int COOL_RATE       = 1,
  parameter int AMBIENT_TEMP    = 100,
  parameter int HEAT_MIN_LEVEL  = 64,
  parameter int MOTOR_ACCEL     = 10,
  parameter int MOTOR_DECEL     = 20,
  parameter int DOOR_DELAY      = 4,
  parameter int DOOR_SAFE_LEVEL = 16,
  parameter int VIB_SPEED       = 700,
  parameter int VIB_LEVEL       = 128,
  parameter int VIB_HOLD        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       water_valve,
  input  logic       heater,
  input  logic       drum_motor,
  input  logic       drain_pump,
  input  logic       door_lock,
`ifdef FAULT_INJECT_EN
  input  logic [1:0] fault_inject,
`endif
  output logic [9:0] water_level,
  output logic [9:0] temperature_adc,
  output logic [9:0] motor_speed_sensor,
  output logic       vibration_sensor,
  output logic       door_locked,
  output logic       tick,
  output logic       overflow
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DOOR_DELAY + 1);
  localparam int VW = $clog2(VIB_HOLD + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_DELAY - 1);
  localparam logic [VW-1:0] VIB_FULL  = VW'(VIB_HOLD);

  localparam logic [10:0] LVL_MAX = 11'd1023;
  localparam logic [10:0] FILL_W  = 11'(FILL_RATE);
  localparam logic [10:0] DRAIN_W = 11'(DRAIN_RATE);
  localparam logic [10:0] HEAT_W  = 11'(HEAT_RATE);
  localparam logic [10:0] ACCEL_W = 11'(MOTOR_ACCEL);

  localparam logic [9:0] AMB_T      = 10'(AMBIENT_TEMP);
  localparam logic [9:0] COOL_T     = 10'(COOL_RATE);
  localparam logic [9:0] DECEL_T    = 10'(MOTOR_DECEL);
  localparam logic [9:0] HEAT_MIN_T = 10'(HEAT_MIN_LEVEL);
  localparam logic [9:0] SAFE_T     = 10'(DOOR_SAFE_LEVEL);
  localparam logic [9:0] VIB_SPD_T  = 10'(VIB_SPEED);
  localparam logic [9:0] VIB_LVL_T  = 10'(VIB_LEVEL);

  localparam logic [1:0] ST_UNLOCKED  = 2'd0;
  localparam logic [1:0] ST_LOCKING   = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;
  localparam logic [1:0] ST_UNLOCKING = 2'd3;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic [9:0]    water_level_q, water_level_d;
  logic [9:0]    temperature_q, temperature_d;
  logic [9:0]    motor_speed_q, motor_speed_d;
  logic          overflow_q, overflow_d;
  logic [VW-1:0] vib_cnt_q, vib_cnt_d;
  logic          vib_q, vib_d;
  logic [1:0]    door_state_q, door_state_d;
  logic [DW-1:0] door_cnt_q, door_cnt_d;
  logic          door_locked_q, door_locked_d;

  logic [10:0] lvl_sum, lvl_raw, tmp_sum, spd_sum;
  logic        heat_on, imbalance;
  logic        fault_vib, fault_heat;

`ifdef FAULT_INJECT_EN
  assign fault_vib  = fault_inject[0];
  assign fault_heat = fault_inject[1];
`else
  assign fault_vib  = 1'b0;
  assign fault_heat = 1'b0;
`endif

  // Free-running tick divider; tick is registered so it lines up with tick_cnt==TICK_DIV-1.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    tick_d     = (tick_cnt_d == TICK_LAST);
  end

  // Plant physics: level, temperature, drum speed and vibration, advanced on tick only.
  always_comb begin
    // Level: add first, then subtract with a floor at zero, so nothing can wrap.
    lvl_sum = {1'b0, water_level_q} + (water_valve ? FILL_W : 11'd0);
    if (drain_pump) begin
      lvl_raw = (lvl_sum >= DRAIN_W) ? (lvl_sum - DRAIN_W) : 11'd0;
    end else begin
      lvl_raw = lvl_sum;
    end

    heat_on = heater && !fault_heat && (water_level_q >= HEAT_MIN_T);
    tmp_sum = {1'b0, temperature_q} + HEAT_W;
    spd_sum = {1'b0, motor_speed_q} + ACCEL_W;

    // Judged on the values currently presented to the controller.
    imbalance = (motor_speed_q >= VIB_SPD_T) && (water_level_q > VIB_LVL_T);

    water_level_d = water_level_q;
    temperature_d = temperature_q;
    motor_speed_d = motor_speed_q;
    overflow_d    = overflow_q;
    vib_cnt_d     = vib_cnt_q;
    vib_d         = vib_q;

    if (tick_q) begin
      water_level_d = (lvl_raw > LVL_MAX) ? 10'h3FF : lvl_raw[9:0];
      if (water_valve && (lvl_raw > LVL_MAX)) begin
        overflow_d = 1'b1;
      end

      if (heat_on) begin
        temperature_d = (tmp_sum > LVL_MAX) ? 10'h3FF : tmp_sum[9:0];
      end else if (temperature_q > AMB_T) begin
        temperature_d = ((temperature_q - AMB_T) > COOL_T) ? (temperature_q - COOL_T) : AMB_T;
      end else if (temperature_q < AMB_T) begin
        temperature_d = ((AMB_T - temperature_q) > COOL_T) ? (temperature_q + COOL_T) : AMB_T;
      end

      if (drum_motor) begin
        motor_speed_d = (spd_sum > LVL_MAX) ? 10'h3FF : spd_sum[9:0];
      end else begin
        motor_speed_d = (motor_speed_q >= DECEL_T) ? (motor_speed_q - DECEL_T) : 10'd0;
      end

      if (imbalance) begin
        vib_cnt_d = (vib_cnt_q == VIB_FULL) ? VIB_FULL : vib_cnt_q + VW'(1);
      end else begin
        vib_cnt_d = '0;
      end
      vib_d = (vib_cnt_d == VIB_FULL) || fault_vib;
    end
  end

  // Door lock FSM with tick-counted lock/unlock delay and the unlock safety interlock.
  always_comb begin
    door_state_d = door_state_q;
    door_cnt_d   = door_cnt_q;
    if (tick_q) begin
      case (door_state_q)
        ST_UNLOCKED: begin
          if (door_lock) begin
            door_state_d = ST_LOCKING;
            door_cnt_d   = '0;
          end
        end
        ST_LOCKING: begin
          if (!door_lock) begin
            door_state_d = ST_UNLOCKED;
          end else if (door_cnt_q == DOOR_LAST) begin
            door_state_d = ST_LOCKED;
          end else begin
            door_cnt_d = door_cnt_q + DW'(1);
          end
        end
        ST_LOCKED: begin
          if (!door_lock && (motor_speed_q == 10'd0) && (water_level_q <= SAFE_T)) begin
            door_state_d = ST_UNLOCKING;
            door_cnt_d   = '0;
          end
        end
        default: begin
          if (door_lock) begin
            door_state_d = ST_LOCKED;
          end else if (door_cnt_q == DOOR_LAST) begin
            door_state_d = ST_UNLOCKED;
          end else begin
            door_cnt_d = door_cnt_q + DW'(1);
          end
        end
      endcase
    end
    door_locked_d = (door_state_d == ST_LOCKED) || (door_state_d == ST_UNLOCKING);
  end

  // State registers; reset wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q    <= '0;
      tick_q        <= 1'b0;
      water_level_q <= 10'd0;
      temperature_q <= AMB_T;
      motor_speed_q <= 10'd0;
      overflow_q    <= 1'b0;
      vib_cnt_q     <= '0;
      vib_q         <= 1'b0;
      door_state_q  <= ST_UNLOCKED;
      door_cnt_q    <= '0;
      door_locked_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      tick_q        <= tick_d;
      water_level_q <= water_level_d;
      temperature_q <= temperature_d;
      motor_speed_q <= motor_speed_d;
      overflow_q    <= overflow_d;
      vib_cnt_q     <= vib_cnt_d;
      vib_q         <= vib_d;
      door_state_q  <= door_state_d;
      door_cnt_q    <= door_cnt_d;
      door_locked_q <= door_locked_d;
    end
  end

  assign water_level        = water_level_q;
  assign temperature_adc    = temperature_q;
  assign motor_speed_sensor = motor_speed_q;
  assign vibration_sensor   = vib_q;
  assign door_locked        = door_locked_q;
  assign tick               = tick_q;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_washer_plant_model.sv
// Bench for washer_plant_model: directed vector table, hand-written reset
// sequence, and randomized commands checked every cycle against a model.
module tb_washer_plant_model;

  localparam int TICK_DIV = 16;
  localparam int FILL     = 8;
  localparam int DRAIN    = 16;
  localparam int HEAT     = 2;
  localparam int COOL     = 1;
  localparam int AMB      = 100;
  localparam int HEAT_MIN = 64;
  localparam int ACC      = 10;
  localparam int DEC      = 20;
  localparam int DDEL     = 4;
  localparam int SAFE     = 16;
  localparam int VSPD     = 700;
  localparam int VLVL     = 128;
  localparam int VHOLD    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, water_valve, heater, drum_motor, drain_pump, door_lock;
  logic [9:0] water_level, temperature_adc, motor_speed_sensor;
  logic       vibration_sensor, door_locked, tick, overflow;

  washer_plant_model dut (
    .clk                (clk),
    .reset              (reset),
    .water_valve        (water_valve),
    .heater             (heater),
    .drum_motor         (drum_motor),
    .drain_pump         (drain_pump),
    .door_lock          (door_lock),
    .water_level        (water_level),
    .temperature_adc    (temperature_adc),
    .motor_speed_sensor (motor_speed_sensor),
    .vibration_sensor   (vibration_sensor),
    .door_locked        (door_locked),
    .tick               (tick),
    .overflow           (overflow)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model, expressed as plain integer physics
  typedef enum {D_OPEN, D_CLOSING, D_SHUT, D_OPENING} door_e;
  int    m_lvl, m_tmp, m_spd, m_run, m_cnt, m_delay;
  bit    m_vib, m_ovf, m_tick;
  door_e m_door;

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_lvl = 0; m_tmp = AMB; m_spd = 0; m_run = 0; m_vib = 0; m_ovf = 0;
    m_door = D_OPEN; m_delay = 0; m_cnt = 0; m_tick = 0;
  endtask

  task automatic model_tick();
    int nl, nt, ns;
    bit imb;
    nl = m_lvl + (water_valve ? FILL : 0) - (drain_pump ? DRAIN : 0);
    if (water_valve && nl > 1023) m_ovf = 1;
    if (heater && m_lvl >= HEAT_MIN) nt = clamp(m_tmp + HEAT, 0, 1023);
    else if (m_tmp > AMB)            nt = clamp(m_tmp - COOL, AMB, 1023);
    else                             nt = clamp(m_tmp + COOL, 0, AMB);
    ns = drum_motor ? clamp(m_spd + ACC, 0, 1023) : clamp(m_spd - DEC, 0, 1023);
    imb = (m_spd >= VSPD) && (m_lvl > VLVL);
    m_run = imb ? clamp(m_run + 1, 0, VHOLD) : 0;
    m_vib = (m_run == VHOLD);
    case (m_door)
      D_OPEN:    if (door_lock) begin m_door = D_CLOSING; m_delay = 0; end
      D_CLOSING: if (!door_lock) m_door = D_OPEN;
                 else begin m_delay++; if (m_delay == DDEL) m_door = D_SHUT; end
      D_SHUT:    if (!door_lock && m_spd == 0 && m_lvl <= SAFE) begin m_door = D_OPENING; m_delay = 0; end
      D_OPENING: if (door_lock) m_door = D_SHUT;
                 else begin m_delay++; if (m_delay == DDEL) m_door = D_OPEN; end
    endcase
    m_lvl = clamp(nl, 0, 1023);
    m_tmp = nt;
    m_spd = ns;
  endtask

  // One clock: advance the model for this edge, then compare all outputs.
  task automatic cycle();
    bit exp_lck;
    if (reset) model_reset();
    else begin
      if (m_tick) model_tick();
      m_cnt  = (m_cnt + 1) % TICK_DIV;
      m_tick = (m_cnt == TICK_DIV - 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_lck = (m_door == D_SHUT) || (m_door == D_OPENING);
    checks++;
    if ({water_level, temperature_adc, motor_speed_sensor, vibration_sensor, door_locked, tick, overflow} !==
        {10'(m_lvl), 10'(m_tmp), 10'(m_spd), m_vib, exp_lck, m_tick, m_ovf}) begin
      failures++;
      $display("FAIL model_cycle cyc=%0d got lvl=%0d tmp=%0d spd=%0d vib=%0b lck=%0b tick=%0b ovf=%0b want lvl=%0d tmp=%0d spd=%0d vib=%0b lck=%0b tick=%0b ovf=%0b",
               cyc, water_level, temperature_adc, motor_speed_sensor, vibration_sensor, door_locked, tick, overflow,
               m_lvl, m_tmp, m_spd, m_vib, exp_lck, m_tick, m_ovf);
    end
  endtask

  task automatic run_ticks(input int n);
    int done = 0;
    while (done < n) begin
      if (m_tick && !reset) done++;
      cycle();
    end
  endtask

  typedef struct {
    logic valve, heat, motor, pump, lock;
    int   ticks;
    int   lvl, tmp, spd;
    logic lck, ovf, vib;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic v, h, m, p, l, input int t, lv, tp, sp, input logic lk, ov, vb);
    vec_t e;
    e.valve = v; e.heat = h; e.motor = m; e.pump = p; e.lock = l; e.ticks = t;
    e.lvl = lv; e.tmp = tp; e.spd = sp; e.lck = lk; e.ovf = ov; e.vib = vb;
    vecs.push_back(e);
  endtask

  task automatic check_state(input string name, input int lv, tp, sp, input logic lk, ov, vb);
    checks++;
    if ({water_level, temperature_adc, motor_speed_sensor, door_locked, overflow, vibration_sensor} !==
        {10'(lv), 10'(tp), 10'(sp), lk, ov, vb}) begin
      failures++;
      $display("FAIL %s got lvl=%0d tmp=%0d spd=%0d lck=%0b ovf=%0b vib=%0b want lvl=%0d tmp=%0d spd=%0d lck=%0b ovf=%0b vib=%0b",
               name, water_level, temperature_adc, motor_speed_sensor, door_locked, overflow, vibration_sensor,
               lv, tp, sp, lk, ov, vb);
    end
  endtask

  initial begin
    int tick_seen;
    int waited;

    //   valve heat motor pump lock ticks  lvl  tmp  spd lck ovf vib
    add(1, 0, 0, 0, 0,  32,  256, 100,   0, 0, 0, 0);   // fill
    add(0, 1, 0, 0, 0,  50,  256, 200,   0, 0, 0, 0);   // heat
    add(0, 0, 0, 0, 0, 100,  256, 100,   0, 0, 0, 0);   // cool back to ambient
    add(1, 0, 0, 0, 0,  96, 1023, 100,   0, 0, 1, 0);   // saturate, overflow
    add(0, 0, 0, 0, 0,   5, 1023, 100,   0, 0, 1, 0);   // overflow sticky
    add(0, 0, 0, 1, 0,  64,    0, 100,   0, 0, 1, 0);   // drain to floor
    add(0, 1, 0, 0, 0,  10,    0, 100,   0, 0, 1, 0);   // heater with no water
    add(1, 0, 0, 0, 0,  38,  304, 100,   0, 0, 1, 0);
    add(0, 0, 0, 0, 1,   4,  304, 100,   0, 0, 1, 0);   // still locking
    add(0, 0, 0, 0, 1,   1,  304, 100,   0, 1, 1, 0);   // locked
    add(0, 0, 1, 0, 1,  70,  304, 100, 700, 1, 1, 0);
    add(0, 0, 1, 0, 1,   2,  304, 100, 720, 1, 1, 0);
    add(0, 0, 1, 0, 1,   1,  304, 100, 730, 1, 1, 1);   // third imbalance tick
    add(0, 0, 0, 0, 0,   1,  304, 100, 710, 1, 1, 1);   // interlock holds lock
    add(0, 0, 0, 0, 0,   1,  304, 100, 690, 1, 1, 1);
    add(0, 0, 0, 0, 0,   1,  304, 100, 670, 1, 1, 0);   // vibration drops
    add(0, 0, 0, 1, 0,  34,    0, 100,   0, 1, 1, 0);
    add(0, 0, 0, 1, 0,   1,    0, 100,   0, 1, 1, 0);   // unlocking starts
    add(0, 0, 0, 1, 0,   3,    0, 100,   0, 1, 1, 0);
    add(0, 0, 0, 1, 0,   1,    0, 100,   0, 0, 1, 0);   // unlocked
    add(0, 0, 0, 0, 1,   1,    0, 100,   0, 0, 1, 0);   // locking
    add(0, 0, 0, 0, 0,   1,    0, 100,   0, 0, 1, 0);   // abort lock
    add(0, 0, 0, 0, 1,   4,    0, 100,   0, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1,    0, 100,   0, 1, 1, 0);
    add(0, 0, 0, 0, 0,   1,    0, 100,   0, 1, 1, 0);   // unlocking
    add(0, 0, 0, 0, 1,   1,    0, 100,   0, 1, 1, 0);   // abort unlock
    add(0, 0, 0, 0, 0,   4,    0, 100,   0, 1, 1, 0);
    add(0, 0, 0, 0, 0,   1,    0, 100,   0, 0, 1, 0);

    reset = 1'b1;
    water_valve = 1'b0; heater = 1'b0; drum_motor = 1'b0; drain_pump = 1'b0; door_lock = 1'b0;
    model_reset();
    repeat (3) cycle();
    check_state("reset_values", 0, 100, 0, 0, 0, 0);
    reset = 1'b0;

    tick_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (tick === 1'b1) tick_seen++;
    end
    checks++;
    if (tick_seen != 6) begin
      failures++;
      $display("FAIL idle_tick_count got %0d want 6", tick_seen);
    end
    check_state("idle_state", 0, 100, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      water_valve = vecs[i].valve; heater = vecs[i].heat; drum_motor = vecs[i].motor;
      drain_pump = vecs[i].pump; door_lock = vecs[i].lock;
      run_ticks(vecs[i].ticks);
      check_state($sformatf("vec_%0d", i), vecs[i].lvl, vecs[i].tmp, vecs[i].spd,
                  vecs[i].lck, vecs[i].ovf, vecs[i].vib);
    end

    // Reset in the middle of a fill with the door locked and overflow set
    water_valve = 1'b1; heater = 1'b0; drum_motor = 1'b0; drain_pump = 1'b0; door_lock = 1'b1;
    run_ticks(25);
    check_state("fill_to_200", 200, 100, 0, 1, 1, 0);
    repeat (5) cycle();
    reset = 1'b1;
    cycle();
    check_state("mid_reset", 0, 100, 0, 0, 0, 0);
    reset = 1'b0;
    water_valve = 1'b0; door_lock = 1'b0;
    waited = 0;
    while (tick !== 1'b1 && waited < 40) begin
      cycle();
      waited++;
    end
    checks++;
    if (waited != 15) begin
      failures++;
      $display("FAIL tick_after_reset got %0d cycles want 15", waited);
    end

    // Randomized commands, occasional reset
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        water_valve = ($urandom_range(0, 9) < 5);
        drain_pump  = ($urandom_range(0, 9) < 3);
        heater      = ($urandom_range(0, 1) == 1);
        drum_motor  = ($urandom_range(0, 9) < 7);
        door_lock   = ($urandom_range(0, 9) < 7);
      end
      reset = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
